// File: rtl/mem_access_unit_if.sv
// Memory-side bus of mem_access_unit: the MFA/MFC handshake plus lane-positioned data.
//   mfa         memory function active (unit -> memory)
//   read_write  1 = read, 0 = write
//   memadd      latched byte address
//   be          byte-lane enables, one bit per byte of the data bus
//   memdat_out  write data already placed on its byte lanes
//   memdat_in   read data from memory
//   mfc         memory function complete (memory -> unit)
interface mem_access_unit_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
);
  logic            mfa;
  logic            read_write;
  logic [AW-1:0]   memadd;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   memdat_out;
  logic [DW-1:0]   memdat_in;
  logic            mfc;

  modport master (
    output mfa, read_write, memadd, be, memdat_out,
    input  memdat_in, mfc
  );

  modport slave (
    input  mfa, read_write, memadd, be, memdat_out,
    output memdat_in, mfc
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: byte-lane placement of store data, MFA/MFC
// handshake with optional timeout, and sign/zero extension of load data.
//   clk, rst_n        clock, asynchronous active-low reset
//   req_i             request strobe, sampled only while idle
//   wr_i              1 = store, 0 = load
//   size_i            00 byte, 01 halfword, 10 word, 11 doubleword
//   sign_ext_i        loads: 1 = sign-extend, 0 = zero-extend
//   addr_i, wdata_i   byte address, right-aligned store data
//   rdata_o           extended load result, held until the next successful load
//   busy_o            high whenever not idle
//   done_o            one-cycle completion pulse
//   fault_o           misaligned / illegal size, valid with done_o
//   timeout_o         no MFC within TIMEOUT cycles, valid with done_o
//   mem               memory bus (master side)
// addr_i must be at least 3 bits wide (alignment is checked on the low 3 bits).
module mem_access_unit #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DW-1:0]     wdata_i,
  output logic [DW-1:0]     rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fault_o,
  output logic              timeout_o,
  mem_access_unit_if.master mem
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e          state_q;
  logic            busy_q, done_q, fault_q, timeout_q;
  logic            mfa_q, rw_q, wr_q, sign_q;
  logic [1:0]      size_q;
  logic [OW-1:0]   off_q;
  logic [AW-1:0]   memadd_q;
  logic [NB-1:0]   be_q;
  logic [DW-1:0]   mdo_q, rdata_q;
  logic [CW-1:0]   cnt_q;

  // Request decode: access size, fault check, lane enables and placed write data
  logic [3:0]      n_req;
  logic [OW-1:0]   off_req;
  logic            fault_req;
  logic [NB-1:0]   be_d;
  logic [DW-1:0]   wshift, mdo_d;
  int unsigned     lane_lo, lane_hi;

  always_comb begin
    n_req     = 4'd1 << size_i;
    off_req   = addr_i[OW-1:0];
    fault_req = (|(addr_i[2:0] & 3'(n_req - 4'd1))) || (32'(n_req) > NB);
    lane_lo   = 32'(off_req);
    lane_hi   = lane_lo + 32'(n_req);
    wshift    = wdata_i << {off_req, 3'b000};
    be_d      = '0;
    mdo_d     = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be_d[i]           = (i >= lane_lo) && (i < lane_hi);
      mdo_d[8*i +: 8]   = be_d[i] ? wshift[8*i +: 8] : 8'h00;
    end
  end

  // Load path: bring the addressed lanes down to bit 0, then extend above them
  logic [3:0]      n_acc;
  int unsigned     nbits;
  logic [DW-1:0]   rshift, rdata_d;
  logic            sign_bit;

  always_comb begin
    n_acc    = 4'd1 << size_q;
    nbits    = 32'd8 * 32'(n_acc);
    rshift   = mem.memdat_in >> {off_q, 3'b000};
    sign_bit = 1'b0;
    rdata_d  = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (i == nbits - 32'd1) sign_bit = rshift[i];
    end
    for (int unsigned i = 0; i < DW; i++) begin
      rdata_d[i] = (i < nbits) ? rshift[i] : (sign_q & sign_bit);
    end
  end

  // Control FSM with registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
      mfa_q     <= 1'b0;
      rw_q      <= 1'b0;
      wr_q      <= 1'b0;
      sign_q    <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      memadd_q  <= '0;
      be_q      <= '0;
      mdo_q     <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            busy_q   <= 1'b1;
            memadd_q <= addr_i;
            wr_q     <= wr_i;
            size_q   <= size_i;
            sign_q   <= sign_ext_i;
            off_q    <= off_req;
            if (fault_req) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q <= S_ACCESS;
              mfa_q   <= 1'b1;
              rw_q    <= ~wr_i;
              be_q    <= be_d;
              mdo_q   <= mdo_d;
              cnt_q   <= '0;
            end
          end
        end
        S_ACCESS: begin
          // MFC takes priority over the timeout limit in the same cycle
          if (mem.mfc) begin
            if (!wr_q) rdata_q <= rdata_d;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            mfa_q   <= 1'b0;
            be_q    <= '0;
            mdo_q   <= '0;
          end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            mfa_q     <= 1'b0;
            be_q      <= '0;
            mdo_q     <= '0;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          fault_q   <= 1'b0;
          timeout_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata_o        = rdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign fault_o        = fault_q;
  assign timeout_o      = timeout_q;
  assign mem.mfa        = mfa_q;
  assign mem.read_write = rw_q;
  assign mem.memadd     = memadd_q;
  assign mem.be         = be_q;
  assign mem.memdat_out = mdo_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (DW=32, AW=8, TIMEOUT=4): directed cases with literal
// expectations, a mid-access reset, then randomized transactions against a
// transaction-level model that predicts the output trace cycle by cycle.
module tb_mem_access_unit;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, wr, sign;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy, done, fault, timeout;

  mem_access_unit_if #(.DW(DW), .AW(AW)) mem ();

  mem_access_unit #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .wr_i(wr), .size_i(size),
    .sign_ext_i(sign), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
    .busy_o(busy), .done_o(done), .fault_o(fault), .timeout_o(timeout), .mem(mem)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model expectations for the cycle following the most recent edge
  bit          e_busy, e_done, e_fault, e_to, e_mfa, e_rw;
  bit [AW-1:0] e_addr;
  bit [3:0]    e_be;
  bit [31:0]   e_mdo, e_rdata;

  // Observations gathered during one transaction
  int        mfa_cycles;
  bit        seen_fault, seen_to, seen_rw;
  bit [3:0]  seen_be;
  bit [31:0] seen_mdo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit [31:0] ext(input bit [31:0] rd, input int off, input int n, input bit sx);
    logic [63:0] m, v;
    m = (64'd1 << (8 * n)) - 64'd1;
    v = (64'(rd) >> (8 * off)) & m;
    if (sx && (((v >> (8 * n - 1)) & 64'd1) != 0)) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic set_idle();
    e_busy = 0; e_done = 0; e_fault = 0; e_to = 0; e_mfa = 0; e_be = 4'h0;
  endtask

  task automatic sample();
    if (mem.mfa) begin
      mfa_cycles++;
      seen_be  = mem.be;
      seen_mdo = mem.memdat_out;
      seen_rw  = mem.read_write;
    end
    if (done) begin
      seen_fault = fault;
      seen_to    = timeout;
    end
  endtask

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (e_done) begin
        chk("fault", fault, e_fault);
        chk("timeout", timeout, e_to);
      end
      chk("mfa", mem.mfa, e_mfa);
      chk("be", mem.be, e_be);
      if (e_mfa) begin
        chk("read_write", mem.read_write, e_rw);
        chk("memadd", mem.memadd, e_addr);
        chk("memdat_out", mem.memdat_out, e_mdo);
      end
      chk("rdata", rdata, e_rdata);
    end
  end

  // One complete transaction; lat = edge (1..) at which MFC is presented
  task automatic txn(input bit w, input bit [1:0] sz, input bit sx, input bit [7:0] a,
                     input bit [31:0] wd, input int lat, input bit [31:0] rd);
    int n, off, last;
    bit flt, timed;
    logic [63:0] lm;
    n   = 1 << sz;
    off = a % 4;
    flt = ((a % n) != 0) || (n > 4);
    mfa_cycles = 0; seen_fault = 0; seen_to = 0; seen_rw = 0; seen_be = 0; seen_mdo = 0;
    req = 1; wr = w; size = sz; sign = sx; addr = a; wdata = wd;
    mem.mfc = 0; mem.memdat_in = $urandom;
    step();
    req = 0; addr = 8'($urandom); wdata = $urandom;
    e_busy = 1;
    if (flt) begin
      e_done = 1; e_fault = 1; e_to = 0; e_mfa = 0; e_be = 4'h0;
      sample();
    end else begin
      lm     = ((64'd1 << (8 * n)) - 64'd1) << (8 * off);
      e_mfa  = 1; e_done = 0; e_rw = !w; e_addr = a;
      e_be   = 4'(((1 << n) - 1) << off);
      e_mdo  = 32'((64'(wd) << (8 * off)) & lm);
      sample();
      timed = (lat > TO);
      last  = timed ? TO : lat;
      for (int j = 1; j <= last; j++) begin
        mem.mfc       = (j == lat);
        mem.memdat_in = (j == lat) ? rd : $urandom;
        req           = 1'($urandom % 2);
        step();
        if (j < last) sample();
      end
      e_mfa = 0; e_be = 4'h0; e_done = 1; e_fault = 0; e_to = timed;
      if (!timed && !w) e_rdata = ext(rd, off, n, sx);
      sample();
    end
    // Inputs during the done cycle must be ignored
    mem.mfc = 1'($urandom % 2); req = 1'($urandom % 2); mem.memdat_in = $urandom;
    step();
    set_idle();
    sample();
    req = 0; mem.mfc = 0;
  endtask

  initial begin
    rst_n = 0; req = 0; wr = 0; sign = 0; size = 0; addr = 0; wdata = 0;
    mem.mfc = 0; mem.memdat_in = 0;
    set_idle(); e_rw = 0; e_addr = 0; e_mdo = 0; e_rdata = 0;
    step(); step();
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mfa", mem.mfa, 0);
    chk("rst_be", mem.be, 0);
    chk("rst_rw", mem.read_write, 0);
    rst_n = 1; chk_en = 1;
    step();

    txn(1, 2'd2, 0, 8'h14, 32'hDEADBEEF, 1, 32'h0);
    chk("ws_be", seen_be, 4'b1111);
    chk("ws_mdo", seen_mdo, 32'hDEADBEEF);
    chk("ws_rw", seen_rw, 0);
    chk("ws_mfa_cycles", mfa_cycles, 1);
    chk("ws_fault", seen_fault, 0);

    txn(0, 2'd0, 1, 8'h03, 32'h0, 1, 32'h80112233);
    chk("lbs_be", seen_be, 4'b1000);
    chk("lbs_rdata", rdata, 32'hFFFFFF80);
    txn(0, 2'd0, 0, 8'h03, 32'h0, 2, 32'h80112233);
    chk("lbu_rdata", rdata, 32'h00000080);

    txn(1, 2'd1, 0, 8'h02, 32'h0000ABCD, 1, 32'h0);
    chk("hs_be", seen_be, 4'b1100);
    chk("hs_mdo", seen_mdo, 32'hABCD0000);

    txn(0, 2'd1, 0, 8'h01, 32'h0, 1, 32'h0);
    chk("mis_mfa_cycles", mfa_cycles, 0);
    chk("mis_fault", seen_fault, 1);
    txn(0, 2'd3, 0, 8'h00, 32'h0, 1, 32'h0);
    chk("dw_mfa_cycles", mfa_cycles, 0);
    chk("dw_fault", seen_fault, 1);

    txn(0, 2'd2, 1, 8'h04, 32'h0, 9, 32'h55555555);
    chk("to_mfa_cycles", mfa_cycles, 4);
    chk("to_flag", seen_to, 1);
    chk("to_rdata", rdata, 32'h00000080);
    txn(0, 2'd2, 0, 8'h08, 32'h0, 4, 32'h12345678);
    chk("late_mfc_mfa_cycles", mfa_cycles, 4);
    chk("late_mfc_to", seen_to, 0);
    chk("late_mfc_rdata", rdata, 32'h12345678);

    // Reset asserted in the middle of an access
    req = 1; wr = 0; size = 2'd2; sign = 0; addr = 8'h10; mem.mfc = 0;
    step();
    req = 0; chk_en = 0;
    #1;
    chk("pre_rst_mfa", mem.mfa, 1);
    rst_n = 0;
    #1;
    chk("rst_async_mfa", mem.mfa, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_be", mem.be, 0);
    chk("rst_async_done", done, 0);
    step();
    chk("rst_hold_done", done, 0);
    rst_n = 1;
    set_idle(); e_rdata = 0;
    chk_en = 1;
    step();

    for (int t = 0; t < 200; t++) begin
      bit [1:0] sz;
      bit [7:0] a;
      int n;
      sz = 2'($urandom % 4);
      n  = 1 << sz;
      a  = 8'($urandom);
      if ($urandom % 4 != 0) a = a & 8'(~(n - 1));
      txn(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
          int'($urandom_range(1, 6)), $urandom);
      for (int g = int'($urandom % 3); g > 0; g--) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the fixed MAR/MBR + MFA/MFC memory path of the ARM datapath.
- Accepts one load/store request at a time from the control unit and places write data onto the correct little-endian byte lanes.
- Runs the MFA/MFC handshake with the memory, including a timeout. On loads, it extracts and sign- or zero-extends the addressed lanes.
- Adds halfword access, misalignment faults and timeout detection, which the current path lacks.

Parameters:
- DW, 32: data bus width in bits. Power of two, 16 to 64.
- AW, 8: address width in bits.
- TIMEOUT, 16: maximum ACCESS cycles to wait for MFC. 0 disables the timeout.

Ports:
- Clk  in  1  system clock; all state is updated on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word (32b), 11 = doubleword (legal only when DW=64, otherwise faults).
- sign_ext  in  1  for loads: 1 = sign-extend, 0 = zero-extend.
- addr  in  AW  byte address.
- wdata  in  DW  store data, right-aligned.
- rdata  out  DW  extended load result; holds its value until the next successful load.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  misaligned or illegal size; valid only while done=1.
- timeout  out  1  MFC not received within the limit; valid only while done=1.
- MFA  out  1  memory function active.
- READ_WRITE  out  1  1 = read, 0 = write.
- MEMADD  out  AW  latched address.
- BE  out  DW/8  byte-lane enables.
- MEMDAT_OUT  out  DW  lane-positioned write data.
- MEMDAT_IN  in  DW  memory read data.
- MFC  in  1  memory function complete.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs and latched request fields clear to 0, including rdata and READ_WRITE.
- States: IDLE, ACCESS, DONE. Registered Moore outputs.
- IDLE:
  - On a rising edge with req=1, latch addr, wr, size, sign_ext and wdata.
  - Access bytes N = 1 << size. Offset = addr mod (DW/8).
  - Fault condition: addr mod N != 0, or N > DW/8.
  - If the fault condition holds, go to DONE with fault=1; MFA is never raised.
  - Otherwise go to ACCESS and clear the wait counter.
- ACCESS:
  - MFA=1. MEMADD = latched address. READ_WRITE = ~wr.
  - BE has N bits set, starting at lane = offset.
  - MEMDAT_OUT = wdata shifted left by offset×8. Lanes that are not enabled are driven 0.
  - When MFC=1 at a rising edge:
    - For loads, select N bytes from MEMDAT_IN starting at lane offset, extend to DW bits per sign_ext, and register into rdata.
    - Go to DONE.
  - Otherwise the wait counter increments. When TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no MFC, go to DONE with timeout=1; rdata is unchanged.
  - MFC and the timeout limit in the same cycle: MFC wins and timeout stays 0.
- DONE:
  - done=1 for exactly one cycle; MFA=0 and BE=0. fault and timeout are shown only in this cycle.
  - Then return to IDLE.
- Latency:
  - The request edge is edge 0. MFA is high from just after edge 0.
  - With MFC high at edge 1, done is high between edges 1 and 2.
  - Fault: done is high between edges 0 and 1.
  - Back-to-back: a req held high is accepted on the first IDLE edge after DONE, so the minimum period is 3 cycles.
- Ignored inputs:
  - req outside IDLE.
  - MFC outside ACCESS.
  - Changes to addr or wdata after the latch edge.
- Reset asserted mid-ACCESS: MFA drops immediately (asynchronous). done is not pulsed.
- Wait counter width is clog2(TIMEOUT+1). It never wraps because it is compared before incrementing.

Test Plan:
- Word store, DW=32: addr=0x14, wdata=0xDEADBEEF, MFC returned 1 cycle after MFA → BE=1111, MEMDAT_OUT=0xDEADBEEF, READ_WRITE=0, done 1 cycle, fault=0.
- Signed byte load: addr=0x03, MEMDAT_IN=0x80112233 → BE=1000, rdata=0xFFFFFF80. Same load with sign_ext=0 → rdata=0x00000080.
- Halfword store: addr=0x02, wdata=0x0000ABCD → BE=1100, MEMDAT_OUT=0xABCD0000.
- Misaligned halfword at addr=0x01 → MFA never asserted, done and fault high 1 cycle after req. size=11 with DW=32 → same response.
- MFC held low, TIMEOUT=4 → MFA high exactly 4 cycles, then done=1 and timeout=1, rdata unchanged. MFC arriving on the 4th cycle instead → timeout=0 and load data captured.
- Reset pulled low while MFA=1 → MFA, busy and BE go to 0 without waiting for a clock edge, and no done pulse. After release, req is accepted normally.
